down_counter: RTL and testbench
===============================

// Module: down_counter
//
// PURPOSE
//   Loadable WIDTH-bit binary down counter / programmable delay timer.
//   Counterpart of the binary up counter: takes a start value, counts down to
//   zero on enabled clock edges, and flags the terminal count.
//   Used by stimulus and control blocks as a delay or timeout generator.
//
// PARAMETERS
//   WIDTH    4    counter width in bits; start values range 0 .. 2**WIDTH-1
//
// PORTS
//   clock    input   1      rising-edge clock
//   clear    input   1      asynchronous reset, active-high
//   load     input   1      capture din as the new start value
//   din      input   WIDTH  start value
//   enable   input   1      decrement permission while counting
//   Q        output  WIDTH  current count
//   busy     output  1      high in RUN or PAUSE
//   zero     output  1      high whenever Q == 0
//   done     output  1      one-cycle pulse at terminal count
//
// BEHAVIOUR
//   - All state and outputs are registered on the rising edge of clock.
//   - clear high, without waiting for an edge: Q=0, state=IDLE, busy=0, done=0, zero=1.
//   - FSM states: IDLE, RUN, PAUSE, DONE.
//   - load has priority over enable in every state.
//     - load with din!=0: Q<=din, go to RUN.
//     - load with din==0: Q<=0, go to IDLE, no done pulse.
//   - RUN with enable=1:
//     - Q>1: Q<=Q-1.
//     - Q==1: Q<=0, go to DONE.
//   - RUN with enable=0: go to PAUSE, Q holds.
//   - PAUSE with enable=1: decrement on that same edge, same rules as RUN, go to RUN.
//   - PAUSE with enable=0: hold.
//   - DONE: done=1 for exactly this cycle; next edge goes to IDLE. load in DONE restarts.
//   - IDLE: enable is ignored and Q holds.
//   - Q never wraps below 0; there is no 0 -> 2**WIDTH-1 transition.
//   - Latency: start value N with enable held high gives done N edges after the load edge.
//     N == 2**WIDTH-1 is legal.
//   - load during RUN or PAUSE aborts the current count: no done pulse, restart from din.
//   - load and terminal count on the same edge: load wins, no done pulse.
//   - busy: 1 in RUN and PAUSE, 0 in IDLE and DONE.
//   - zero: combinational (Q == 0).
//
// CONFIGURATION
//   DOWN_COUNTER_RELOAD_EN
//     - Defined:
//       - load also captures din into a reload register.
//       - On the terminal edge (RUN, enable=1, Q==1): Q<=reload, done pulses for one
//         cycle, state stays RUN. This gives a periodic tick every reload enabled edges.
//       - Exit auto-reload by loading 0, or by clear.
//       - DONE state is unused.
//     - Undefined: one-shot behaviour as described above; no reload register is
//       synthesised.
//
// TESTING
//   1. Reset: clear=1 at time 0, with and without a clock running
//      -> Q=0, zero=1, busy=0, done=0 at once; hold after clear=0 with no load.
//   2. One-shot: load din=5, enable=1 held
//      -> Q goes 5,4,3,2,1,0 on successive edges; done=1 for one cycle with Q=0;
//         busy=0 from the next edge; Q stays 0 (no wrap).
//   3. Pause: load 3; enable=1 for 1 edge, then 0 for 3 edges
//      -> Q holds 2 and busy=1 throughout; enable=1 again -> done after 2 more edges.
//   4. Async clear mid-count: load 9, run until Q=4, pulse clear between edges
//      -> Q=0 before the next edge; no done pulse; state IDLE.
//   5. Reload mid-count: load 9, run until Q=4, load din=12
//      -> Q=12 next edge, no done pulse; done only after 12 further enabled edges.
//      Also: load 15 with WIDTH=4 -> done 15 edges after the load edge.
//   6. RELOAD_EN build: load 3, enable=1 held
//      -> Q repeats 3,2,1,3,2,1; done pulses every 3 edges; busy stays 1;
//         load 0 -> Q=0, busy=0, pulses stop.

Source files
------------

// File: rtl/down_counter.sv
// Loadable WIDTH-bit down counter / delay timer with terminal-count pulse.
// Define DOWN_COUNTER_RELOAD_EN for periodic auto-reload instead of one-shot.
module down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             enable,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             zero,
  output logic             done
);

  localparam logic [WIDTH-1:0] ZERO = WIDTH'(0);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             term_s;
`ifdef DOWN_COUNTER_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // Next-state, next-count and registered-output logic
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    term_s  = 1'b0;
`ifdef DOWN_COUNTER_RELOAD_EN
    reload_d = reload_q;
`endif
    if (load) begin
      count_d = din;
`ifdef DOWN_COUNTER_RELOAD_EN
      reload_d = din;
`endif
      if (din != ZERO) begin
        state_d = ST_RUN;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RUN, ST_PAUSE: begin
          if (enable) begin
            if (count_q > ONE) begin
              count_d = count_q - ONE;
              state_d = ST_RUN;
            end else if (count_q == ONE) begin
              term_s = 1'b1;
`ifdef DOWN_COUNTER_RELOAD_EN
              count_d = reload_q;
              state_d = ST_RUN;
`else
              count_d = ZERO;
              state_d = ST_DONE;
`endif
            end else begin
              // A zero count while counting is unreachable; never wrap.
              count_d = ZERO;
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_PAUSE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          count_d = ZERO;
        end
      endcase
    end
    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    done_d = term_s;
  end

  // State, count and output registers with asynchronous clear
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
      count_q <= ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef DOWN_COUNTER_RELOAD_EN
  // Auto-reload value captured on every load
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      reload_q <= ZERO;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  assign Q    = count_q;
  assign busy = busy_q;
  assign done = done_q;
  assign zero = (count_q == ZERO);

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: directed scenarios plus randomized
// traffic compared against a behavioural model of the count.
module tb_down_counter;

  localparam int WIDTH = 4;

  logic             clock = 1'b0;
  logic             clear = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             enable = 1'b0;
  logic [WIDTH-1:0] Q;
  logic             busy, zero, done;
  logic             clk_run = 1'b0;

  int checks = 0;
  int errors = 0;

  // Behavioural model: remaining count, whether a count is in progress
  int m_count  = 0;
  int m_reload = 0;
  bit m_active = 1'b0;
  bit m_done   = 1'b0;

  down_counter #(.WIDTH(WIDTH)) dut (
    .clock(clock), .clear(clear), .load(load), .din(din), .enable(enable),
    .Q(Q), .busy(busy), .zero(zero), .done(done)
  );

  always begin
    #5;
    if (clk_run) clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".Q"},    32'(Q),    32'(m_count));
    check({tag, ".busy"}, 32'(busy), 32'(m_active));
    check({tag, ".zero"}, 32'(zero), 32'(m_count == 0));
    check({tag, ".done"}, 32'(done), 32'(m_done));
  endtask

  task automatic model_clear();
    m_count  = 0;
    m_reload = 0;
    m_active = 1'b0;
    m_done   = 1'b0;
  endtask

  task automatic model_edge(input bit l, input int d, input bit e);
    m_done = 1'b0;
    if (l) begin
      m_count  = d;
      m_reload = d;
      m_active = (d != 0);
    end else if (m_active && e) begin
      m_count = m_count - 1;
      if (m_count == 0) begin
        m_done = 1'b1;
`ifdef DOWN_COUNTER_RELOAD_EN
        m_count = m_reload;
`else
        m_active = 1'b0;
`endif
      end
    end
  endtask

  // Drive inputs, take one rising edge, then compare 1 time unit later
  task automatic step(input string tag, input bit l, input int d, input bit e);
    load   = l;
    din    = WIDTH'(d);
    enable = e;
    @(posedge clock);
    model_edge(l, d, e);
    #1;
    check_all(tag);
  endtask

  task automatic pulse_clear(input string tag);
    clear = 1'b1;
    #1;
    model_clear();
    check_all(tag);
    clear = 1'b0;
  endtask

  initial begin
    int n;
    bit seen;
    // Reset with no clock running
    #1;
    clear = 1'b1;
    #2;
    check_all("reset_noclk");
    check("reset_noclk.Qconst", 32'(Q), 32'd0);
    clk_run = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_all("reset_clk");
    clear = 1'b0;
    step("hold_after_clear", 1'b0, 0, 1'b1);
    step("hold_after_clear2", 1'b0, 0, 1'b1);

    // One-shot from 5
    step("load5", 1'b1, 5, 1'b1);
    check("load5.Qconst", 32'(Q), 32'd5);
    for (int i = 0; i < 8; i++) step("run5", 1'b0, 0, 1'b1);
    check("run5.nowrap", 32'(Q), 32'd0);

    // Pause
    step("load3", 1'b1, 3, 1'b1);
    step("p_run", 1'b0, 0, 1'b1);
    for (int i = 0; i < 3; i++) step("p_hold", 1'b0, 0, 1'b0);
    check("p_hold.Qconst", 32'(Q), 32'd2);
    for (int i = 0; i < 3; i++) step("p_resume", 1'b0, 0, 1'b1);

    // Async clear mid-count
    step("load9a", 1'b1, 9, 1'b1);
    for (int i = 0; i < 5; i++) step("run9a", 1'b0, 0, 1'b1);
    check("run9a.Qconst", 32'(Q), 32'd4);
    #2;
    pulse_clear("midclear");
    for (int i = 0; i < 3; i++) step("after_clear", 1'b0, 0, 1'b1);

    // Reload mid-count, then a full-range count
    step("load9b", 1'b1, 9, 1'b1);
    for (int i = 0; i < 5; i++) step("run9b", 1'b0, 0, 1'b1);
    step("reload12", 1'b1, 12, 1'b1);
    for (int i = 0; i < 13; i++) step("run12", 1'b0, 0, 1'b1);
    step("load15", 1'b1, 15, 1'b1);
    n = 0;
    seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step("run15", 1'b0, 0, 1'b1);
      if (done && !seen) begin
        n = i;
        seen = 1'b1;
      end
    end
    check("latency15", 32'(n), 32'd15);

    // Load on the terminal edge wins; load 0 gives no pulse
    step("load2", 1'b1, 2, 1'b1);
    step("run2", 1'b0, 0, 1'b1);
    step("load_at_term", 1'b1, 7, 1'b1);
    step("load0", 1'b1, 0, 1'b1);
    step("idle_en", 1'b0, 0, 1'b1);

    // Periodic scenario (auto-reload build repeats, one-shot build stops)
    step("per_load3", 1'b1, 3, 1'b1);
    for (int i = 0; i < 7; i++) step("per_run", 1'b0, 0, 1'b1);
    step("per_load0", 1'b1, 0, 1'b1);
    for (int i = 0; i < 3; i++) step("per_stop", 1'b0, 0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(63) == 0) begin
        pulse_clear("rnd_clear");
      end
      step("rnd", ($urandom_range(7) == 0), int'($urandom_range(15)),
           ($urandom_range(3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
